regfile_param: RTL and testbench

- Parametrised general-purpose register file for the single-cycle datapath; replaces the fixed 32x32 register file.
- Configurable data width and depth, optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a sequential bulk-clear engine that zeroes the array one entry per cycle on request, reporting a busy flag.
- Sits between the instruction decoder/control unit (addresses, regwrite) and the ALU/writeback mux (read data, write data).

---
 rtl/regfile_param_if.sv | 29 ++
 rtl/regfile_param.sv | 113 +++++++++++
 tb/tb_regfile_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Register-file bus: decoder/control side drives addresses, write data and
// clear requests; the register file returns read data and clear status.
//   master : decoder / control unit side
//   slave  : register file side
interface regfile_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  regwrite;
  logic [ADDR_WIDTH-1:0] writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic [ADDR_WIDTH-1:0] readRegister1;
  logic [ADDR_WIDTH-1:0] readRegister2;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic                  clear_req;
  logic                  clear_busy;
  logic                  write_dropped;

  modport master (
    output regwrite, writeRegister, writeData, readRegister1, readRegister2, clear_req,
    input  readData1, readData2, clear_busy, write_dropped
  );

  modport slave (
    input  regwrite, writeRegister, writeData, readRegister1, readRegister2, clear_req,
    output readData1, readData2, clear_busy, write_dropped
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with optional hardwired-zero register 0,
// optional write-to-read bypass, and a one-entry-per-cycle bulk-clear engine.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset (clears the whole array)
//   bus    : regfile_param_if.slave -- write port, two combinational read
//            ports, clear_req in, clear_busy / write_dropped out
//
// state | meaning
// IDLE  | normal operation, writes and bypass enabled
// SWEEP | clearing entry cnt_q each cycle, user writes dropped
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic            clock,
  input  logic            reset,
  regfile_param_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  dropped_q, dropped_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Single physical write port shared by user writes and the sweep.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dropped_d = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = bus.writeRegister;
    wr_data   = bus.writeData;
    case (state_q)
      IDLE: begin
        if (bus.regwrite && !((ZERO_REG != 0) && (bus.writeRegister == '0)))
          wr_en = 1'b1;
        // A write in the same cycle as clear_req still commits; the sweep
        // reaches that entry later.
        if (bus.clear_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        wr_en     = 1'b1;
        wr_addr   = cnt_q;
        wr_data   = '0;
        dropped_d = bus.regwrite;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == SWEEP);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] r;
    if ((ZERO_REG != 0) && (addr == '0))
      r = '0;
    else if ((BYPASS != 0) && bus.regwrite && (state_q == IDLE) && (bus.writeRegister == addr))
      r = bus.writeData;
    else
      r = mem_q[addr];
    return r;
  endfunction

  assign bus.readData1     = read_port(bus.readRegister1);
  assign bus.readData2     = read_port(bus.readRegister2);
  assign bus.clear_busy    = busy_q;
  assign bus.write_dropped = dropped_q;
endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;
  logic        clock = 1'b0;
  logic        reset;
  logic        regwrite;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [4:0]  rr1, rr2;
  logic        clear_req;

  always #5 clock = ~clock;

  // dut_a: zero register + bypass; dut_b: plain register 0, no bypass.
  regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
  regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();

  assign bus_a.regwrite = regwrite;      assign bus_b.regwrite = regwrite;
  assign bus_a.writeRegister = wreg;     assign bus_b.writeRegister = wreg;
  assign bus_a.writeData = wdata;        assign bus_b.writeData = wdata;
  assign bus_a.readRegister1 = rr1;      assign bus_b.readRegister1 = rr1;
  assign bus_a.readRegister2 = rr2;      assign bus_b.readRegister2 = rr2;
  assign bus_a.clear_req = clear_req;    assign bus_b.clear_req = clear_req;

  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  localparam int A_RD1 = 0, A_RD2 = 1, A_BUSY = 2, A_DROP = 3;
  localparam int B_RD1 = 4, B_RD2 = 5, B_BUSY = 6, B_DROP = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sel_val(input int sel);
    case (sel)
      A_RD1:   return bus_a.readData1;
      A_RD2:   return bus_a.readData2;
      A_BUSY:  return {31'd0, bus_a.clear_busy};
      A_DROP:  return {31'd0, bus_a.write_dropped};
      B_RD1:   return bus_b.readData1;
      B_RD2:   return bus_b.readData2;
      B_BUSY:  return {31'd0, bus_b.clear_busy};
      default: return {31'd0, bus_b.write_dropped};
    endcase
  endfunction

  // Monitor: every falling edge, compare all expectations queued this cycle.
  always @(negedge clock) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c   = q.pop_front();
      act = sel_val(c.sel);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic exp_chk(input string n, input int sel, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.sel  = sel;
    c.exp  = e;
    q.push_back(c);
  endtask

  task automatic chk_now(input string n, input int sel, input logic [31:0] e);
    logic [31:0] act;
    act = sel_val(sel);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; regwrite = 1'b0; wreg = '0; wdata = '0;
    rr1 = '0; rr2 = '0; clear_req = 1'b0;
    #1;
    chk_now("rst_now_busy_a", A_BUSY, 0);
    chk_now("rst_now_rd1_b", B_RD1, 0);
    exp_chk("rst_busy_a", A_BUSY, 0);
    exp_chk("rst_drop_a", A_DROP, 0);
    cyc(); cyc();
    reset = 1'b1;

    // All entries read zero after reset on both ports.
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(31 - i);
      exp_chk("rst_rd1_a", A_RD1, 0);
      exp_chk("rst_rd2_a", A_RD2, 0);
      exp_chk("rst_rd1_b", B_RD1, 0);
      exp_chk("rst_rd2_b", B_RD2, 0);
      exp_chk("rst_busy_b", B_BUSY, 0);
      cyc();
    end

    // Write and readback.
    regwrite = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF; rr1 = 5'd0; rr2 = 5'd0;
    cyc();
    regwrite = 1'b0; rr1 = 5'd5; rr2 = 5'd5;
    exp_chk("wr5_rd1_a", A_RD1, 32'hDEADBEEF);
    exp_chk("wr5_rd2_a", A_RD2, 32'hDEADBEEF);
    exp_chk("wr5_rd1_b", B_RD1, 32'hDEADBEEF);
    exp_chk("wr5_rd2_b", B_RD2, 32'hDEADBEEF);
    cyc();

    // Zero register.
    regwrite = 1'b1; wreg = 5'd0; wdata = 32'h12345678; rr1 = 5'd0;
    exp_chk("zero_byp_a", A_RD1, 0);
    exp_chk("zero_nobyp_b", B_RD1, 0);
    cyc();
    regwrite = 1'b0;
    exp_chk("zero_rd_a", A_RD1, 0);
    exp_chk("zero_drop_a", A_DROP, 0);
    exp_chk("zero_rd_b", B_RD1, 32'h12345678);
    cyc();

    // Bypass.
    regwrite = 1'b1; wreg = 5'd7; wdata = 32'h11111111;
    cyc();
    wdata = 32'hA5A5A5A5; rr1 = 5'd7; rr2 = 5'd7;
    exp_chk("byp_rd1_a", A_RD1, 32'hA5A5A5A5);
    exp_chk("byp_rd2_a", A_RD2, 32'hA5A5A5A5);
    exp_chk("nobyp_rd1_b", B_RD1, 32'h11111111);
    cyc();
    regwrite = 1'b0;
    exp_chk("byp_after_a", A_RD1, 32'hA5A5A5A5);
    exp_chk("byp_after_b", B_RD1, 32'hA5A5A5A5);
    cyc();

    // Fill regs 1..31 with index*3.
    for (int i = 1; i < 32; i++) begin
      regwrite = 1'b1; wreg = 5'(i); wdata = 32'(i * 3);
      cyc();
    end
    regwrite = 1'b0; rr1 = 5'd3; rr2 = 5'd31;
    exp_chk("fill_r3_a", A_RD1, 9);
    exp_chk("fill_r31_b", B_RD2, 93);
    cyc();

    // Clear request together with a write to reg 20: the write commits first.
    clear_req = 1'b1; regwrite = 1'b1; wreg = 5'd20; wdata = 32'h0000CAFE; rr2 = 5'd20;
    exp_chk("clr_byp_a", A_RD2, 32'h0000CAFE);
    exp_chk("clr_busy0_a", A_BUSY, 0);
    cyc();
    clear_req = 1'b0; regwrite = 1'b0;
    for (int k = 0; k < 32; k++) begin
      regwrite  = (k == 10);
      wreg      = 5'd10;
      wdata     = 32'h00000BAD;
      clear_req = (k == 15);
      exp_chk("sw_busy_a", A_BUSY, 1);
      exp_chk("sw_busy_b", B_BUSY, 1);
      exp_chk("sw_drop_a", A_DROP, (k == 11) ? 32'd1 : 32'd0);
      exp_chk("sw_r3_a", A_RD1, (k <= 3) ? 32'd9 : 32'd0);
      exp_chk("sw_r3_b", B_RD1, (k <= 3) ? 32'd9 : 32'd0);
      exp_chk("sw_r20_a", A_RD2, (k <= 20) ? 32'h0000CAFE : 32'd0);
      cyc();
    end
    regwrite = 1'b0; clear_req = 1'b0;
    chk_now("sw_done_busy_a", A_BUSY, 0);
    chk_now("sw_done_r20_a", A_RD2, 0);
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(i);
      if (i == 0) begin
        exp_chk("sw_end_busy_a", A_BUSY, 0);
        exp_chk("sw_end_drop_a", A_DROP, 0);
      end
      exp_chk("sw_end_rd1_a", A_RD1, 0);
      exp_chk("sw_end_rd2_b", B_RD2, 0);
      cyc();
    end

    // Reset in the middle of a sweep.
    regwrite = 1'b1; wreg = 5'd9; wdata = 32'h00000099;
    cyc();
    regwrite = 1'b0; clear_req = 1'b1;
    cyc();
    clear_req = 1'b0; rr1 = 5'd9; rr2 = 5'd31;
    for (int k = 0; k < 5; k++) begin
      exp_chk("pre_rst_r9_a", A_RD1, 32'h00000099);
      exp_chk("pre_rst_busy_a", A_BUSY, 1);
      cyc();
    end
    reset = 1'b0;
    #1;
    chk_now("mid_rst_now_busy_a", A_BUSY, 0);
    chk_now("mid_rst_now_r9_a", A_RD1, 0);
    exp_chk("mid_rst_busy_a", A_BUSY, 0);
    exp_chk("mid_rst_r9_a", A_RD1, 0);
    exp_chk("mid_rst_r9_b", B_RD1, 0);
    cyc();
    reset = 1'b1;
    exp_chk("post_rst_busy_a", A_BUSY, 0);
    exp_chk("post_rst_r9_a", A_RD1, 0);
    exp_chk("post_rst_r31_b", B_RD2, 0);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
